// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and timing constants for the key debouncer
package key_pkg;

    // Per-channel hold tracking: idle, held before long-press, held after long-press.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        LONG = 2'd2
    } hold_state_e;

    // Default timing at a 125 MHz system clock.
    localparam int unsigned T_10MS  = 32'd1250000;
    localparam int unsigned T_1S    = 32'd125000000;
    localparam int unsigned T_200MS = 32'd25000000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// rtl/key_debounce_chan.sv - one key channel: synchroniser, debounce, hold FSM, event pulses
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   key_i          : raw asynchronous key pin
//   state_o        : debounced level, 1 = pressed
//   press_o        : 1-cycle pulse on accepted press
//   release_o      : 1-cycle pulse on accepted release
//   long_o         : 1-cycle pulse when the hold reaches LONG_CYCLES
//   repeat_o       : 1-cycle pulse every REPEAT_CYCLES after long_o
//   press_next_o   : next-state value of press_o, lets the top register any_press alongside
module key_debounce_chan
    import key_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = T_10MS,
    parameter int unsigned LONG_CYCLES   = T_1S,
    parameter int unsigned REPEAT_CYCLES = T_200MS,
    parameter int unsigned REPEAT_EN     = 1,
    parameter int unsigned ACTIVE_LOW    = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic state_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o,
    output logic press_next_o
);

    localparam int unsigned DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(max_u(LONG_CYCLES, REPEAT_CYCLES) + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;
    localparam logic              REL_LVL   = (ACTIVE_LOW != 0);

    logic              sync1_q, sync2_q;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic              state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    hold_state_e       fsm_q, fsm_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              repeat_q, repeat_d;
    logic              lvl;

    // Pin polarity folded away here: lvl is 1 while the key is pressed.
    assign lvl = sync2_q ^ REL_LVL;

    always_comb begin
        deb_cnt_d = '0;
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (lvl != state_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                state_d   = lvl;
                press_d   = lvl;
                release_d = ~lvl;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    // Release wins over every other transition, so no long/repeat in the release cycle.
    always_comb begin
        fsm_d      = fsm_q;
        hold_cnt_d = hold_cnt_q;
        long_d     = 1'b0;
        repeat_d   = 1'b0;
        if (release_d) begin
            fsm_d      = IDLE;
            hold_cnt_d = '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    hold_cnt_d = '0;
                    if (press_d) begin
                        fsm_d = HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt_q == LONG_LAST) begin
                        long_d     = 1'b1;
                        hold_cnt_d = '0;
                        fsm_d      = LONG;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                LONG: begin
                    if (REPEAT_EN != 0) begin
                        if (hold_cnt_q == REP_LAST) begin
                            repeat_d   = 1'b1;
                            hold_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                        end
                    end else if (hold_cnt_q != HOLD_MAX) begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                default: begin
                    fsm_d      = IDLE;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q    <= REL_LVL;
            sync2_q    <= REL_LVL;
            deb_cnt_q  <= '0;
            state_q    <= 1'b0;
            hold_cnt_q <= '0;
            fsm_q      <= IDLE;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            sync1_q    <= key_i;
            sync2_q    <= sync1_q;
            deb_cnt_q  <= deb_cnt_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            fsm_q      <= fsm_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            repeat_q   <= repeat_d;
        end
    end

    assign state_o      = state_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_o       = long_q;
    assign repeat_o     = repeat_q;
    assign press_next_o = press_d;

endmodule

// File: rtl/key_debounce_multi.sv
// rtl/key_debounce_multi.sv - N-channel key debouncer with press/release/long/repeat events
//   clk, rst     : clock, asynchronous active-high reset
//   key_in       : raw asynchronous key pins
//   key_state    : debounced levels, 1 = pressed
//   key_press    : per-key 1-cycle press pulses
//   key_release  : per-key 1-cycle release pulses
//   key_long     : per-key 1-cycle long-press pulses
//   key_repeat   : per-key 1-cycle auto-repeat pulses
//   any_press    : OR of key_press, aligned with key_press
module key_debounce_multi
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS        = 4,
    parameter int unsigned DEB_CYCLES    = T_10MS,
    parameter int unsigned LONG_CYCLES   = T_1S,
    parameter int unsigned REPEAT_CYCLES = T_200MS,
    parameter int unsigned REPEAT_EN     = 1,
    parameter int unsigned ACTIVE_LOW    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic [N_KEYS-1:0] key_repeat,
    output logic              any_press
);

    if (N_KEYS < 1 || DEB_CYCLES < 2 || LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
        $fatal(1, "key_debounce_multi: N_KEYS >= 1 and all cycle counts >= 2 required");
    end

    logic [N_KEYS-1:0] press_next;
    logic              any_press_q;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_chan
        key_debounce_chan #(
            .DEB_CYCLES    (DEB_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .REPEAT_EN     (REPEAT_EN),
            .ACTIVE_LOW    (ACTIVE_LOW)
        ) u_chan (
            .clk_i        (clk),
            .rst_i        (rst),
            .key_i        (key_in[k]),
            .state_o      (key_state[k]),
            .press_o      (key_press[k]),
            .release_o    (key_release[k]),
            .long_o       (key_long[k]),
            .repeat_o     (key_repeat[k]),
            .press_next_o (press_next[k])
        );
    end

    // Registered from the channels' next-press terms so it lands on the key_press edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= |press_next;
        end
    end

    assign any_press = any_press_q;

endmodule

// File: tb/tb_key_debounce_multi.sv
// tb/tb_key_debounce_multi.sv - scoreboard bench for key_debounce_multi
module tb_key_debounce_multi;

    localparam int DEB  = 4;
    localparam int LNG  = 10;
    localparam int REP  = 3;
    localparam int LAT  = DEB + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] key_in = 2'b11;

    logic [1:0] st0, pr0, rl0, lg0, rp0;
    logic [1:0] st1, pr1, rl1, lg1, rp1;
    logic       ap0, ap1;

    key_debounce_multi #(
        .N_KEYS(2), .DEB_CYCLES(DEB), .LONG_CYCLES(LNG), .REPEAT_CYCLES(REP),
        .REPEAT_EN(1), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .key_in(key_in),
        .key_state(st0), .key_press(pr0), .key_release(rl0),
        .key_long(lg0), .key_repeat(rp0), .any_press(ap0)
    );

    key_debounce_multi #(
        .N_KEYS(2), .DEB_CYCLES(DEB), .LONG_CYCLES(LNG), .REPEAT_CYCLES(REP),
        .REPEAT_EN(0), .ACTIVE_LOW(1)
    ) dut_norep (
        .clk(clk), .rst(rst), .key_in(key_in),
        .key_state(st1), .key_press(pr1), .key_release(rl1),
        .key_long(lg1), .key_repeat(rp1), .any_press(ap1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 press, 1 release, 2 long, 3 repeat; dut: 0 repeat enabled, 1 repeat disabled
    typedef struct {
        int cyc;
        int dut;
        int kind;
        int ch;
    } ev_t;

    ev_t        sb[$];
    int         errors = 0;
    int         checks = 0;
    logic [1:0] exp_st0 = 2'b00;
    logic [1:0] exp_st1 = 2'b00;
    logic [7:0] exp_v0, exp_v1;

    task automatic push_ev(input int c, input int d, input int k, input int ch);
        ev_t e;
        e.cyc = c; e.dut = d; e.kind = k; e.ch = ch;
        sb.push_back(e);
    endtask

    // Pin pressed at negedge c_pin; hold events stop before edge 'stop' (release edge or reset).
    task automatic plan_hold(input int ch, input int c_pin, input int stop, input bit rel);
        int p, l;
        p = c_pin + LAT;
        l = p + LNG;
        for (int d = 0; d < 2; d++) begin
            if (p < stop) push_ev(p, d, 0, ch);
            if (l < stop) begin
                push_ev(l, d, 2, ch);
                if (d == 0) begin
                    for (int t = l + REP; t < stop; t += REP) push_ev(t, d, 3, ch);
                end
            end
            if (rel) push_ev(stop, d, 1, ch);
        end
    endtask

    always @(negedge clk) begin
        exp_v0 = '0;
        exp_v1 = '0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                checks++;
                assert (sb[i].cyc === cyc) else begin
                    errors++;
                    $error("FAIL stale_event observed=%0d expected=%0d", cyc, sb[i].cyc);
                end
                if (sb[i].dut == 0) exp_v0[sb[i].kind*2 + sb[i].ch] = 1'b1;
                else                exp_v1[sb[i].kind*2 + sb[i].ch] = 1'b1;
                sb.delete(i);
            end
        end
        exp_st0 = (exp_st0 | exp_v0[1:0]) & ~exp_v0[3:2];
        exp_st1 = (exp_st1 | exp_v1[1:0]) & ~exp_v1[3:2];

        checks++;
        assert ({rp0, lg0, rl0, pr0} === exp_v0) else begin
            errors++;
            $error("FAIL events_rep cyc=%0d observed=%b expected=%b", cyc, {rp0, lg0, rl0, pr0}, exp_v0);
        end
        checks++;
        assert ({rp1, lg1, rl1, pr1} === exp_v1) else begin
            errors++;
            $error("FAIL events_norep cyc=%0d observed=%b expected=%b", cyc, {rp1, lg1, rl1, pr1}, exp_v1);
        end
        checks++;
        assert ({ap1, ap0} === {|exp_v1[1:0], |exp_v0[1:0]}) else begin
            errors++;
            $error("FAIL any_press cyc=%0d observed=%b expected=%b", cyc, {ap1, ap0}, {|exp_v1[1:0], |exp_v0[1:0]});
        end
        checks++;
        assert ({st1, st0} === {exp_st1, exp_st0}) else begin
            errors++;
            $error("FAIL key_state cyc=%0d observed=%b expected=%b", cyc, {st1, st0}, {exp_st1, exp_st0});
        end
    end

    task automatic check_zero(input string tag);
        checks++;
        assert ({st0, pr0, rl0, lg0, rp0, ap0, st1, pr1, rl1, lg1, rp1, ap1} === 22'd0) else begin
            errors++;
            $error("FAIL %s observed=%b expected=0", tag,
                   {st0, pr0, rl0, lg0, rp0, ap0, st1, pr1, rl1, lg1, rp1, ap1});
        end
    endtask

    initial begin
        int c;
        int d;

        repeat (3) @(negedge clk);
        check_zero("reset_state");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // clean press and release on key 0
        @(negedge clk);
        c = cyc;
        key_in[0] = 1'b0;
        plan_hold(0, c, c + 8 + LAT, 1'b1);
        repeat (8) @(negedge clk);
        key_in[0] = 1'b1;
        repeat (12) @(negedge clk);

        // bounce: two 3-cycle lows never qualify
        key_in[0] = 1'b0;
        repeat (3) @(negedge clk);
        key_in[0] = 1'b1;
        @(negedge clk);
        key_in[0] = 1'b0;
        repeat (3) @(negedge clk);
        key_in[0] = 1'b1;
        repeat (8) @(negedge clk);
        c = cyc;
        key_in[0] = 1'b0;
        plan_hold(0, c, c + 6 + LAT, 1'b1);
        repeat (6) @(negedge clk);
        key_in[0] = 1'b1;
        repeat (10) @(negedge clk);

        // long press with auto-repeat on key 1
        c = cyc;
        key_in[1] = 1'b0;
        plan_hold(1, c, c + 30 + LAT, 1'b1);
        repeat (30) @(negedge clk);
        key_in[1] = 1'b1;
        repeat (12) @(negedge clk);

        // both keys pressed together
        c = cyc;
        key_in = 2'b00;
        plan_hold(0, c, c + 5 + LAT, 1'b1);
        plan_hold(1, c, c + 5 + LAT, 1'b1);
        repeat (5) @(negedge clk);
        key_in = 2'b11;
        repeat (10) @(negedge clk);

        // async reset while key 1 is in the LONG state
        c = cyc;
        key_in[1] = 1'b0;
        plan_hold(1, c, c + LAT + LNG + 3, 1'b0);
        repeat (LAT + LNG + 2) @(negedge clk);
        #2;
        rst = 1'b1;
        exp_st0 = 2'b00;
        exp_st1 = 2'b00;
        #1;
        check_zero("async_reset");
        repeat (3) @(negedge clk);
        check_zero("reset_held");
        rst = 1'b0;
        d = cyc;
        plan_hold(1, d, d + 20 + LAT, 1'b1);
        repeat (20) @(negedge clk);
        key_in[1] = 1'b1;
        repeat (12) @(negedge clk);

        checks++;
        assert (sb.size() === 0) else begin
            errors++;
            $error("FAIL pending_events observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
